matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Parametrised HPS-to-coprocessor operand loader.
- Receives element pairs (A, B) over a 32-bit PIO word using a 4-phase req/ack handshake, stores them in two DIM×DIM operand banks, and latches opcode and matrix dimension.
- After the last element it pulses a start to the arithmetic core, waits for completion, and reports status back to the HPS.
- Sits between the HPS PIO registers and the arithmetic datapath.

Parameters:
- DATA_W, 8, element width in bits (max 8, limited by the hps_in field layout).
- MAX_DIM, 5, largest supported matrix dimension (the bank holds MAX_DIM*MAX_DIM entries).
- OPC_W, 3, opcode width.
- IDX_W, $clog2(MAX_DIM*MAX_DIM), element index width (derived; do not override).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- hps_in  in  32  command word. [7:0] A element; [15:8] B element; [18:16] opcode; [21:19] dim; [30] clear; [31] req. Synchronous to clk.
- hps_out  out  32  status word. [31] ack; [30] busy; [29] done; [28] error; [IDX_W-1:0] element count; all other bits 0.
- core_start  out  1  one-cycle start pulse to the arithmetic core
- core_opcode  out  OPC_W  latched opcode
- core_dim  out  3  latched dimension
- rd_idx  in  IDX_W  core read address (row-major)
- rd_a  out  DATA_W  bank A at rd_idx; combinational; 0 if rd_idx ≥ dim*dim
- rd_b  out  DATA_W  bank B at rd_idx; same rules as rd_a
- core_done  in  1  core finished (level or pulse; sampled in WAIT_CORE only)

Behaviour:
- Reset values:
  - hps_out = 0, core_start = 0, core_opcode = 0, core_dim = 0, idx = 0.
  - State goes to IDLE.
  - Bank contents are not reset; reads beyond the loaded count return 0 via the range check.
- States:
  - IDLE: req=1 → accept word, set ack, go to ACK.
  - ACK: hold ack until req=0; then clear ack, go to IDLE, or go to START if the load is complete.
  - START: core_start=1 for exactly one cycle, then WAIT_CORE.
  - WAIT_CORE: core_done=1 → set done, clear busy, go to IDLE.
- Accept rules in IDLE, first matching rule wins:
  - clear=1: idx←0, done←0, error←0, nothing stored, ack handshake still completed.
  - idx==0 and (dim==0 or dim>MAX_DIM): error←1, nothing stored, idx stays 0, ack given.
  - idx==0, valid dim: latch opcode and dim into core_opcode/core_dim, store A/B at index 0, done←0, error←0, idx←1 (applied on req fall).
  - idx>0: store A/B at idx; the opcode and dim fields of the word are ignored; idx increments on req fall.
- Completion:
  - On req fall, if the incremented idx equals core_dim*core_dim: idx←0, busy←1, go to START.
  - Latency: core_start asserts 1 cycle after the req=0 sample.
- Count field: reports the current idx; 0 after completion or clear.
- Busy: busy=1 from START entry until core_done. While busy, req is ignored (no ack, no store). A req still high when returning to IDLE is accepted then.
- Exactly one store per handshake, regardless of how long req stays high.
- Ack rises the cycle after the req=1 sample and falls the cycle after the req=0 sample.
- Reset mid-load or mid-run: immediate return to IDLE, all outputs cleared, partial data abandoned.
- dim*dim is computed in 6 bits; MAX_DIM must not exceed 7.

Decomposition:
- Package matrix_loader_pkg:
  - State enum (IDLE, ACK, START, WAIT_CORE).
  - hps_in/hps_out bit-position constants (REQ_BIT=31, CLR_BIT=30, ACK_BIT=31, BUSY_BIT=30, DONE_BIT=29, ERR_BIT=28, field LSB/MSB).
- One sub-module, operand_bank: dual array (A/B) with one write port and one combinational read port, parametrised by DATA_W and depth.

Test Plan:
- dim=2, op=3: four handshakes with A/B = (1,10),(2,20),(3,30),(4,40) → core_dim=2, core_opcode=3, a single core_start pulse, rd_idx=3 gives rd_a=4, rd_b=40, busy=1.
- Hold req high for 10 cycles on the first element of a dim=3 load → exactly one store, count=1 after req falls, ack high during those cycles.
- First word with dim=0, then with dim=6 → error=1, count=0, no store, ack still toggles. Next valid dim=1 word → error=0 and core_start fires.
- While busy, assert req → no ack, no store, count unchanged. core_done=1 → done=1, busy=0.
- Load 5 of 9 elements, send clear → count=0, done=0, error=0. A fresh dim=3 load completes normally after 9 handshakes.
- Assert reset during ACK with ack=1 → hps_out=0, core_start=0, state IDLE. rd_idx=0 returns 0.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the HPS operand loader: FSM states, PIO word bit layout
// and the dim*dim helper used for completion and read range checks.
package matrix_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    START,
    WAIT_CORE
  } state_e;

  // hps_in layout
  localparam int unsigned A_LSB   = 0;
  localparam int unsigned B_LSB   = 8;
  localparam int unsigned OPC_LSB = 16;
  localparam int unsigned DIM_LSB = 19;
  localparam int unsigned DIM_MSB = 21;
  localparam int unsigned CLR_BIT = 30;
  localparam int unsigned REQ_BIT = 31;

  // hps_out layout
  localparam int unsigned ACK_BIT  = 31;
  localparam int unsigned BUSY_BIT = 30;
  localparam int unsigned DONE_BIT = 29;
  localparam int unsigned ERR_BIT  = 28;

  function automatic logic [5:0] dim_sq(input logic [2:0] d);
    return 6'(d) * 6'(d);
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// HPS PIO command/status word pair; the HPS side is the master.
interface matrix_loader_if;
  logic [31:0] hps_in;
  logic [31:0] hps_out;

  modport master (output hps_in, input hps_out);
  modport slave  (input hps_in, output hps_out);
endinterface

// File: rtl/operand_bank.sv
// Paired A/B operand storage: one synchronous write port, one combinational read port.
module operand_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 25,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_a,
  input  logic [DATA_W-1:0] i_wr_b,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b
);

  logic [DATA_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_b [DEPTH];
  logic              w_rd_ok;

  // Contents are intentionally not reset; the loader masks unloaded entries.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem_a[i_wr_idx] <= i_wr_a;
      r_mem_b[i_wr_idx] <= i_wr_b;
    end
  end

  assign w_rd_ok = (32'(i_rd_idx) < DEPTH);
  assign o_rd_a  = w_rd_ok ? r_mem_a[i_rd_idx] : '0;
  assign o_rd_b  = w_rd_ok ? r_mem_b[i_rd_idx] : '0;

endmodule

// File: rtl/matrix_loader.sv
// Loads DIM x DIM operand pairs from the HPS over a 4-phase req/ack PIO handshake,
// then starts the arithmetic core and reports busy/done/error status.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned IDX_W   = $clog2(MAX_DIM * MAX_DIM)
) (
  input  logic              clk,
  input  logic              reset,
  matrix_loader_if.slave    hps,
  output logic              core_start,
  output logic [OPC_W-1:0]  core_opcode,
  output logic [2:0]        core_dim,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              core_done
);

  localparam logic [2:0] MaxDim = 3'(MAX_DIM);

  state_e             r_state, w_state_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic               r_inc, w_inc_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [OPC_W-1:0]   r_opc, w_opc_nxt;
  logic [2:0]         r_dim, w_dim_nxt;

  logic               w_req, w_clr, w_dim_ok, w_we;
  logic [DATA_W-1:0]  w_a, w_b, w_bank_a, w_bank_b;
  logic [OPC_W-1:0]   w_opc;
  logic [2:0]         w_dim;
  logic [5:0]         w_sq, w_idx_inc;
  logic               w_unused;

  assign w_req     = hps.hps_in[REQ_BIT];
  assign w_clr     = hps.hps_in[CLR_BIT];
  assign w_a       = hps.hps_in[A_LSB +: DATA_W];
  assign w_b       = hps.hps_in[B_LSB +: DATA_W];
  assign w_opc     = hps.hps_in[OPC_LSB +: OPC_W];
  assign w_dim     = hps.hps_in[DIM_MSB:DIM_LSB];
  assign w_dim_ok  = (w_dim != 3'd0) && (w_dim <= MaxDim);
  assign w_sq      = dim_sq(r_dim);
  assign w_idx_inc = 6'(r_idx) + 6'd1;
  assign w_unused  = ^hps.hps_in[29:22];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_inc   <= 1'b0;
      r_idx   <= '0;
      r_opc   <= '0;
      r_dim   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_inc   <= w_inc_nxt;
      r_idx   <= w_idx_nxt;
      r_opc   <= w_opc_nxt;
      r_dim   <= w_dim_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_inc_nxt   = r_inc;
    w_idx_nxt   = r_idx;
    w_opc_nxt   = r_opc;
    w_dim_nxt   = r_dim;
    w_we        = 1'b0;
    core_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_ack_nxt   = 1'b1;
          w_inc_nxt   = 1'b0;
          w_state_nxt = ACK;
          if (w_clr) begin
            w_idx_nxt  = '0;
            w_done_nxt = 1'b0;
            w_err_nxt  = 1'b0;
          end else if (r_idx == '0 && !w_dim_ok) begin
            w_err_nxt = 1'b1;
          end else if (r_idx == '0) begin
            w_opc_nxt  = w_opc;
            w_dim_nxt  = w_dim;
            w_done_nxt = 1'b0;
            w_err_nxt  = 1'b0;
            w_we       = 1'b1;
            w_inc_nxt  = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_inc_nxt = 1'b1;
          end
        end
      end
      ACK: begin
        if (!w_req) begin
          w_ack_nxt   = 1'b0;
          w_inc_nxt   = 1'b0;
          w_state_nxt = IDLE;
          // Index only advances on req fall, so a long req can never double-count.
          if (r_inc) begin
            if (w_idx_inc == w_sq) begin
              w_idx_nxt   = '0;
              w_busy_nxt  = 1'b1;
              w_state_nxt = START;
            end else begin
              w_idx_nxt = IDX_W'(w_idx_inc);
            end
          end
        end
      end
      START: begin
        core_start  = 1'b1;
        w_state_nxt = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hps.hps_out              = '0;
    hps.hps_out[ACK_BIT]     = r_ack;
    hps.hps_out[BUSY_BIT]    = r_busy;
    hps.hps_out[DONE_BIT]    = r_done;
    hps.hps_out[ERR_BIT]     = r_err;
    hps.hps_out[IDX_W-1:0]   = r_idx;
  end

  assign core_opcode = r_opc;
  assign core_dim    = r_dim;

  operand_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DIM * MAX_DIM),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk      (clk),
    .i_we     (w_we),
    .i_wr_idx (r_idx),
    .i_wr_a   (w_a),
    .i_wr_b   (w_b),
    .i_rd_idx (rd_idx),
    .o_rd_a   (w_bank_a),
    .o_rd_b   (w_bank_b)
  );

  // Anything past the loaded matrix reads as zero, including stale bank data.
  assign rd_a = (6'(rd_idx) < w_sq) ? w_bank_a : '0;
  assign rd_b = (6'(rd_idx) < w_sq) ? w_bank_b : '0;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed scenario bench for matrix_loader; expected values are hand-computed.
module tb_matrix_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       core_start;
  logic [2:0] core_opcode;
  logic [2:0] core_dim;
  logic [4:0] rd_idx = '0;
  logic [7:0] rd_a, rd_b;
  logic       core_done = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         start_cnt = 0;

  matrix_loader_if hps_if ();

  matrix_loader u_dut (
    .clk         (clk),
    .reset       (reset),
    .hps         (hps_if),
    .core_start  (core_start),
    .core_opcode (core_opcode),
    .core_dim    (core_dim),
    .rd_idx      (rd_idx),
    .rd_a        (rd_a),
    .rd_b        (rd_b),
    .core_done   (core_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start) start_cnt++;

  wire       s_ack  = hps_if.hps_out[31];
  wire       s_busy = hps_if.hps_out[30];
  wire       s_done = hps_if.hps_out[29];
  wire       s_err  = hps_if.hps_out[28];
  wire [4:0] s_cnt  = hps_if.hps_out[4:0];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_ack === lvl) seen = 1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: ack=%0b, expected %0b", tag, s_ack, lvl);
    end
  endtask

  task automatic hs(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                    input logic [2:0] dim, input logic clr);
    hps_if.hps_in = {1'b1, clr, 8'h00, dim, op, b, a};
    wait_ack(1'b1, "ack_rise");
    hps_if.hps_in[31] = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic finish_core();
    core_done = 1'b1;
    cycles(1);
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    hps_if.hps_in = '0;
    cycles(2);
    reset = 1'b0;
    cycles(1);
    n_tests++;
    if (hps_if.hps_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_hps_out: got %h want 0", hps_if.hps_out);
    end
    n_tests++;
    if ({core_start, core_opcode, core_dim} !== 7'h0) begin
      n_fail++; $display("FAIL reset_core: got %b want 0", {core_start, core_opcode, core_dim});
    end
  endtask

  task automatic test_load_dim2();
    int s0 = start_cnt;
    hs(8'd1, 8'd10, 3'd3, 3'd2, 1'b0);
    hs(8'd2, 8'd20, 3'd3, 3'd2, 1'b0);
    hs(8'd3, 8'd30, 3'd3, 3'd2, 1'b0);
    hs(8'd4, 8'd40, 3'd3, 3'd2, 1'b0);
    cycles(3);
    n_tests++;
    if (start_cnt - s0 !== 1) begin
      n_fail++; $display("FAIL load2_start: got %0d pulses want 1", start_cnt - s0);
    end
    n_tests++;
    if ({core_dim, core_opcode} !== {3'd2, 3'd3}) begin
      n_fail++; $display("FAIL load2_dim_op: got %0d/%0d want 2/3", core_dim, core_opcode);
    end
    rd_idx = 5'd3;
    #1;
    n_tests++;
    if ({rd_a, rd_b} !== {8'd4, 8'd40}) begin
      n_fail++; $display("FAIL load2_rd3: got %0d/%0d want 4/40", rd_a, rd_b);
    end
    rd_idx = 5'd4;
    #1;
    n_tests++;
    if ({rd_a, rd_b} !== 16'h0) begin
      n_fail++; $display("FAIL load2_rd4_range: got %0d/%0d want 0/0", rd_a, rd_b);
    end
    n_tests++;
    if ({s_busy, s_done, s_cnt} !== {1'b1, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL load2_status: got %b want 1_0_00000", {s_busy, s_done, s_cnt});
    end
  endtask

  task automatic test_busy_ignore();
    bit ack_seen = 0;
    hps_if.hps_in = {1'b1, 1'b0, 8'h00, 3'd2, 3'd1, 8'h99, 8'h99};
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      if (s_ack) ack_seen = 1;
    end
    n_tests++;
    if (ack_seen) begin
      n_fail++; $display("FAIL busy_no_ack: ack=1 seen want 0");
    end
    rd_idx = 5'd0;
    #1;
    n_tests++;
    if ({rd_a, rd_b, s_cnt} !== {8'd1, 8'd10, 5'd0}) begin
      n_fail++; $display("FAIL busy_no_store: got %0d/%0d cnt %0d want 1/10 cnt 0", rd_a, rd_b, s_cnt);
    end
    hps_if.hps_in = '0;
    cycles(1);
    finish_core();
    n_tests++;
    if ({s_done, s_busy} !== 2'b10) begin
      n_fail++; $display("FAIL busy_done: got done/busy %b want 10", {s_done, s_busy});
    end
  endtask

  task automatic test_error_dim();
    int s0;
    hs(8'hEE, 8'hEE, 3'd1, 3'd0, 1'b0);
    n_tests++;
    if ({s_err, s_cnt} !== {1'b1, 5'd0}) begin
      n_fail++; $display("FAIL err_dim0: got err %0b cnt %0d want 1 0", s_err, s_cnt);
    end
    hs(8'hEE, 8'hEE, 3'd1, 3'd6, 1'b0);
    rd_idx = 5'd0;
    #1;
    n_tests++;
    if ({s_err, s_cnt, core_dim, rd_a} !== {1'b1, 5'd0, 3'd2, 8'd1}) begin
      n_fail++; $display("FAIL err_dim6: got err %0b cnt %0d dim %0d rd_a %0d want 1 0 2 1",
                         s_err, s_cnt, core_dim, rd_a);
    end
    s0 = start_cnt;
    hs(8'd7, 8'd70, 3'd5, 3'd1, 1'b0);
    cycles(3);
    n_tests++;
    if ({s_err, core_dim, core_opcode} !== {1'b0, 3'd1, 3'd5} || start_cnt - s0 !== 1) begin
      n_fail++; $display("FAIL err_recover: got err %0b dim %0d op %0d pulses %0d want 0 1 5 1",
                         s_err, core_dim, core_opcode, start_cnt - s0);
    end
    rd_idx = 5'd1;
    #1;
    n_tests++;
    if (rd_a !== 8'd0) begin
      n_fail++; $display("FAIL dim1_range: got rd_a %0d want 0", rd_a);
    end
    finish_core();
  endtask

  task automatic test_hold_req();
    bit ack_ok = 1;
    hps_if.hps_in = {1'b1, 1'b0, 8'h00, 3'd3, 3'd2, 8'd50, 8'd5};
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (s_ack !== 1'b1 || s_cnt !== 5'd0) ack_ok = 0;
    end
    n_tests++;
    if (!ack_ok) begin
      n_fail++; $display("FAIL hold_ack: ack/cnt wrong during hold, now ack %0b cnt %0d want 1 0",
                         s_ack, s_cnt);
    end
    hps_if.hps_in[31] = 1'b0;
    wait_ack(1'b0, "hold_ack_fall");
    rd_idx = 5'd0;
    #1;
    n_tests++;
    if ({s_cnt, s_done, rd_a, rd_b} !== {5'd1, 1'b0, 8'd5, 8'd50}) begin
      n_fail++; $display("FAIL hold_one_store: got cnt %0d done %0b rd %0d/%0d want 1 0 5/50",
                         s_cnt, s_done, rd_a, rd_b);
    end
  endtask

  task automatic test_clear_reload();
    int s0;
    for (int i = 1; i < 5; i++) hs(8'(i), 8'(i), 3'd2, 3'd3, 1'b0);
    n_tests++;
    if (s_cnt !== 5'd5) begin
      n_fail++; $display("FAIL partial_cnt: got %0d want 5", s_cnt);
    end
    hs(8'h00, 8'h00, 3'd0, 3'd0, 1'b1);
    n_tests++;
    if ({s_cnt, s_done, s_err, s_busy} !== 8'h0) begin
      n_fail++; $display("FAIL clear: got cnt %0d done %0b err %0b busy %0b want all 0",
                         s_cnt, s_done, s_err, s_busy);
    end
    s0 = start_cnt;
    hs(8'd1, 8'd10, 3'd6, 3'd3, 1'b0);
    // Later words carry junk opcode/dim that must be ignored.
    for (int i = 1; i < 9; i++) hs(8'(i + 1), 8'(10 * (i + 1)), 3'd0, 3'd7, 1'b0);
    cycles(3);
    n_tests++;
    if (start_cnt - s0 !== 1 || {core_dim, core_opcode} !== {3'd3, 3'd6}) begin
      n_fail++; $display("FAIL reload: got pulses %0d dim %0d op %0d want 1 3 6",
                         start_cnt - s0, core_dim, core_opcode);
    end
    rd_idx = 5'd8;
    #1;
    n_tests++;
    if ({rd_a, rd_b} !== {8'd9, 8'd90}) begin
      n_fail++; $display("FAIL reload_rd8: got %0d/%0d want 9/90", rd_a, rd_b);
    end
    rd_idx = 5'd4;
    #1;
    n_tests++;
    if ({rd_a, rd_b} !== {8'd5, 8'd50}) begin
      n_fail++; $display("FAIL reload_rd4: got %0d/%0d want 5/50", rd_a, rd_b);
    end
    rd_idx = 5'd9;
    #1;
    n_tests++;
    if ({rd_a, rd_b} !== 16'h0) begin
      n_fail++; $display("FAIL reload_rd9_range: got %0d/%0d want 0/0", rd_a, rd_b);
    end
    finish_core();
    n_tests++;
    if ({s_done, s_busy} !== 2'b10) begin
      n_fail++; $display("FAIL reload_done: got done/busy %b want 10", {s_done, s_busy});
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    hps_if.hps_in = {1'b1, 1'b0, 8'h00, 3'd2, 3'd4, 8'h22, 8'h11};
    wait_ack(1'b1, "mid_ack_rise");
    reset = 1'b1;
    #1;
    n_tests++;
    if (hps_if.hps_out !== 32'h0 || core_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got hps_out %h start %0b want 0 0",
                         hps_if.hps_out, core_start);
    end
    hps_if.hps_in = '0;
    cycles(1);
    reset = 1'b0;
    cycles(1);
    rd_idx = 5'd0;
    #1;
    n_tests++;
    if ({hps_if.hps_out, core_dim, core_opcode, rd_a} !== 46'h0) begin
      n_fail++; $display("FAIL reset_mid_after: got out %h dim %0d op %0d rd_a %0d want 0",
                         hps_if.hps_out, core_dim, core_opcode, rd_a);
    end
    s0 = start_cnt;
    hs(8'd3, 8'd4, 3'd2, 3'd1, 1'b0);
    cycles(3);
    n_tests++;
    if (start_cnt - s0 !== 1) begin
      n_fail++; $display("FAIL reset_mid_idle: got %0d pulses want 1", start_cnt - s0);
    end
    finish_core();
  endtask

  initial begin
    hps_if.hps_in = '0;
    test_reset();
    test_load_dim2();
    test_busy_ignore();
    test_error_dim();
    test_hold_req();
    test_clear_reload();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
